// File: rtl/div32_seq_if.sv
// div32_seq_if: start/busy/done handshake with operand and result lines for div32_seq.
interface div32_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dz;
    modport master (output start, sgn, dividend, divisor, input busy, done, quotient, remainder, dz);
    modport slave (input start, sgn, dividend, divisor, output busy, done, quotient, remainder, dz);
endinterface

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider, quotient to LO and remainder to HI.
// Signed DIV (abs on entry, negation at FIX) is built only when DIV_SIGNED_EN is defined.
module div32_seq #(parameter int WIDTH = 32) (
    input logic        clk,
    input logic        rst,
    div32_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, q_q, q_d, dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
    logic             dz_q, dz_d, done_q, done_d;
    logic [WIDTH-1:0] mag_dvd, mag_dsr, fix_q, fix_r;
    logic [WIDTH:0]   trial;
    logic             accept;
    assign accept = state_q == IDLE && bus.start;
    assign trial = {rem_q, q_q[WIDTH-1]} - {1'b0, dsr_q};
`ifdef DIV_SIGNED_EN
    logic neg_q_q, neg_r_q, s_dvd, s_dsr;
    assign s_dvd = bus.sgn & bus.dividend[WIDTH-1];
    assign s_dsr = bus.sgn & bus.divisor[WIDTH-1];
    assign mag_dvd = s_dvd ? -bus.dividend : bus.dividend;
    assign mag_dsr = s_dsr ? -bus.divisor : bus.divisor;
    assign fix_q = neg_q_q ? -q_q : q_q;
    assign fix_r = neg_r_q ? -rem_q : rem_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            neg_q_q <= s_dvd ^ s_dsr;
            neg_r_q <= s_dvd;
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = bus.sgn;
    assign mag_dvd = bus.dividend;
    assign mag_dsr = bus.divisor;
    assign fix_q = q_q;
    assign fix_r = rem_q;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        q_d = q_q;
        dsr_d = dsr_q;
        quo_d = quo_q;
        rmd_d = rmd_q;
        dz_d = dz_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = CALC;
                cnt_d = 6'(WIDTH);
                rem_d = '0;
                q_d = mag_dvd;
                dsr_d = mag_dsr;
            end
            CALC: begin
                rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], q_q[WIDTH-1]} : trial[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - 6'd1;
                state_d = cnt_q == 6'd1 ? FIX : CALC;
            end
            FIX: begin
                state_d = IDLE;
                done_d = 1'b1;
                dz_d = dsr_q == '0;
                quo_d = dz_d ? '1 : fix_q;
                // With a zero divisor rem holds |dividend|; re-applying its sign restores the raw bits
                rmd_d = fix_r;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rem_q <= '0;
            q_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dz_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            q_q <= q_d;
            dsr_q <= dsr_d;
            quo_q <= quo_d;
            rmd_q <= rmd_d;
            dz_q <= dz_d;
            done_q <= done_d;
        end
    end
    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.quotient = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.dz = dz_q;
endmodule
